// File: rtl/serial_add_unit.sv
// Digit-serial adder: adds DIGIT bits per clock, LSB first, carry kept in a flop.
// Ports: clk, rst_n, start, a, b, cin, [sub when SERIAL_ADD_SUB_EN] -> sum, carry_out, overflow, busy, done.
module serial_add_unit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] ds_ext;
  logic [DIGIT-1:0] ds;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             dc;
  logic             dmsb;
  logic             c;
  logic             last;
  logic             ld;
  logic             sub_i;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b0;
`endif

  // Ripple through one digit; dmsb is the carry into the digit's top bit,
  // which on the last digit is the carry into the word MSB.
  always_comb begin
    c    = carry;
    dmsb = carry;
    ds   = '0;
    for (int i = 0; i < DIGIT; i++) begin
      dmsb  = c;
      ds[i] = a_q[i] ^ b_q[i] ^ c;
      c     = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
    end
    dc = c;
  end

  // New digit enters at the top; after N shifts the word is aligned.
  always_comb begin
    ds_ext            = '0;
    ds_ext[DIGIT-1:0] = ds;
    acc_nx = (acc >> DIGIT) | (ds_ext << (WIDTH - DIGIT));
  end

  assign last = (cnt == CW'(N - 1));
  assign busy = (state == RUN);

  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          ld       = 1'b1;
        end
      end
      RUN: begin
        if (last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Subtract is a + ~b + ~cin, so inversion happens once at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ld) begin
        a_q   <= a;
        b_q   <= b ^ {WIDTH{sub_i}};
        carry <= cin ^ sub_i;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_q   <= a_q >> DIGIT;
        b_q   <= b_q >> DIGIT;
        carry <= dc;
        acc   <= acc_nx;
        cnt   <= cnt + 1'b1;
        if (last) begin
          sum       <= acc_nx;
          carry_out <= dc;
          overflow  <= dmsb ^ dc;
          done      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_add_unit.sv
// Scoreboard bench for serial_add_unit: W8/D1, W8/D4 and W1/D1 instances.
// Expected results are hand-computed and queued at issue; monitors check on done.
module tb_serial_add_unit;

  typedef struct {
    logic [7:0] s;
    logic       co;
    logic       ov;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  exp_t q1[$];
  exp_t q4[$];
  exp_t qw[$];

  logic       st1 = 0, st4 = 0, stw = 0;
  logic [7:0] a1 = 0, b1 = 0, a4 = 0, b4 = 0;
  logic       aw = 0, bw = 0;
  logic       ci1 = 0, ci4 = 0, ciw = 0;
  logic       sb1 = 0, sb4 = 0, sbw = 0;
  logic [7:0] s1, s4;
  logic       sw;
  logic       co1, co4, cow, ov1, ov4, ovw;
  logic       bz1, bz4, bzw, dn1, dn4, dnw;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_add_unit #(.WIDTH(8), .DIGIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st1),
    .a(a1), .b(b1), .cin(ci1),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sb1),
`endif
    .sum(s1), .carry_out(co1), .overflow(ov1),
    .busy(bz1), .done(dn1)
  );

  serial_add_unit #(.WIDTH(8), .DIGIT(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(st4),
    .a(a4), .b(b4), .cin(ci4),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sb4),
`endif
    .sum(s4), .carry_out(co4), .overflow(ov4),
    .busy(bz4), .done(dn4)
  );

  serial_add_unit #(.WIDTH(1), .DIGIT(1)) uw (
    .clk(clk), .rst_n(rst_n), .start(stw),
    .a(aw), .b(bw), .cin(ciw),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sbw),
`endif
    .sum(sw), .carry_out(cow), .overflow(ovw),
    .busy(bzw), .done(dnw)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic spurious(input string name);
    checks++;
    errors++;
    $display("FAIL %s: done with no pending op", name);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && dn1) begin
      if (q1.size() == 0) spurious("d1_done");
      else begin
        e = q1.pop_front();
        chk("d1_sum", int'(s1), int'(e.s));
        chk("d1_co", int'(co1), int'(e.co));
        chk("d1_ov", int'(ov1), int'(e.ov));
        chk("d1_lat", cyc, e.due);
        chk("d1_busy", int'(bz1), 0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && dn4) begin
      if (q4.size() == 0) spurious("d4_done");
      else begin
        e = q4.pop_front();
        chk("d4_sum", int'(s4), int'(e.s));
        chk("d4_co", int'(co4), int'(e.co));
        chk("d4_ov", int'(ov4), int'(e.ov));
        chk("d4_lat", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && dnw) begin
      if (qw.size() == 0) spurious("w1_done");
      else begin
        e = qw.pop_front();
        chk("w1_sum", int'(sw), int'(e.s));
        chk("w1_co", int'(cow), int'(e.co));
        chk("w1_ov", int'(ovw), int'(e.ov));
        chk("w1_lat", cyc, e.due);
      end
    end
  end

  // sel: 0 = W8/D1, 1 = W8/D4, 2 = W1/D1. Called at a negedge.
  task automatic issue(input int sel, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic sb, input logic [7:0] es,
                       input logic eco, input logic eov, input bit push);
    exp_t e;
    e.s  = es;
    e.co = eco;
    e.ov = eov;
    case (sel)
      0: begin
        a1 = a; b1 = b; ci1 = ci; sb1 = sb; st1 = 1;
        e.due = cyc + 1 + 8;
        if (push) q1.push_back(e);
      end
      1: begin
        a4 = a; b4 = b; ci4 = ci; sb4 = sb; st4 = 1;
        e.due = cyc + 1 + 2;
        if (push) q4.push_back(e);
      end
      default: begin
        aw = a[0]; bw = b[0]; ciw = ci; sbw = sb; stw = 1;
        e.due = cyc + 1 + 1;
        if (push) qw.push_back(e);
      end
    endcase
    @(negedge clk);
    case (sel)
      0: begin chk("d1_busy_on", int'(bz1), 1); st1 = 0; end
      1: begin chk("d4_busy_on", int'(bz4), 1); st4 = 0; end
      default: begin chk("w1_busy_on", int'(bzw), 1); stw = 0; end
    endcase
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q1.size() + q4.size() + qw.size()) != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if ((q1.size() + q4.size() + qw.size()) != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d ops still pending after %0d cycles",
               q1.size() + q4.size() + qw.size(), n);
      q1.delete(); q4.delete(); qw.delete();
    end
    @(negedge clk);
  endtask

  // W1 full-adder table: {a,b,cin} -> {sum,co,ov}
  logic [2:0] fa_tab [8] = '{3'b000, 3'b101, 3'b100, 3'b010,
                             3'b100, 3'b010, 3'b011, 3'b110};

  int c0;

  initial begin
    @(negedge clk);
    chk("rst_sum", int'(s1), 0);
    chk("rst_co", int'(co1), 0);
    chk("rst_ov", int'(ov1), 0);
    chk("rst_busy", int'(bz1), 0);
    chk("rst_done", int'(dn1), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    issue(0, 8'h0F, 8'h01, 0, 0, 8'h10, 0, 0, 1);
    drain();
    issue(0, 8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, 1);
    drain();
    issue(0, 8'h7F, 8'h01, 0, 0, 8'h80, 0, 1, 1);
    drain();
    issue(0, 8'h12, 8'h34, 1, 0, 8'h47, 0, 0, 1);
    drain();
    issue(0, 8'h80, 8'h80, 0, 0, 8'h00, 1, 1, 1);
    drain();

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [2:0] r;
      v = 3'(i);
      r = fa_tab[i];
      issue(2, {7'b0, v[2]}, {7'b0, v[1]}, v[0], 0,
            {7'b0, r[2]}, r[1], r[0], 1);
      drain();
    end

    // Start held through RUN, operands changed after capture,
    // then re-accepted in the done cycle.
    c0 = cyc;
    a4 = 8'hA5; b4 = 8'h5A; ci4 = 1; sb4 = 0; st4 = 1;
    q4.push_back('{s: 8'h00, co: 1'b1, ov: 1'b0, due: c0 + 3});
    @(negedge clk);
    a4 = 8'h10; b4 = 8'h20; ci4 = 0;
    q4.push_back('{s: 8'h30, co: 1'b0, ov: 1'b0, due: c0 + 6});
    while (cyc < c0 + 4) @(negedge clk);
    st4 = 0;
    drain();
    issue(1, 8'h7F, 8'h7F, 1, 0, 8'hFF, 0, 1, 1);
    drain();

    // Abort mid-operation with reset.
    issue(0, 8'h12, 8'h34, 0, 0, 8'h00, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort_sum", int'(s1), 0);
    chk("abort_co", int'(co1), 0);
    chk("abort_ov", int'(ov1), 0);
    chk("abort_busy", int'(bz1), 0);
    chk("abort_done", int'(dn1), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    repeat (12) @(negedge clk);
    chk("abort_idle", int'(bz1), 0);
    issue(0, 8'h01, 8'h02, 0, 0, 8'h03, 0, 0, 1);
    drain();

`ifdef SERIAL_ADD_SUB_EN
    issue(0, 8'h05, 8'h07, 0, 1, 8'hFE, 0, 0, 1);
    drain();
    issue(0, 8'h80, 8'h01, 0, 1, 8'h7F, 1, 1, 1);
    drain();
    issue(1, 8'h10, 8'h03, 1, 1, 8'h0C, 1, 0, 1);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
